// File: rtl/sprite_fetch_ctrl.sv
// sprite_fetch_ctrl: streams one sprite from a synchronous ROM
// into a valid/ready pixel port, tagging each pixel with x/y.
module sprite_fetch_ctrl #(
    parameter int SPR_W = 23,
    parameter int SPR_H = 22,
    parameter int AW = 9,
    parameter int DW = 4,
    parameter logic [DW-1:0] TRANSP = 4'h0
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [DW-1:0] pix_data,
    output logic          pix_opaque,
    output logic [4:0]    pix_x,
    output logic [4:0]    pix_y,
    output logic          pix_last
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(SPR_W * SPR_H - 1);
    localparam logic [4:0] X_MAX = 5'(SPR_W - 1);
    localparam logic [4:0] Y_MAX = 5'(SPR_H - 1);

    state_t        state;
    logic          addr_v;
    logic          data_v;
    logic [DW-1:0] fifo_mem [4];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    fifo_cnt;
    logic [2:0]    occupancy;
    logic          room;
    logic          issue;
    logic          push;
    logic          pop;
    logic [AW-1:0] next_addr;

    // Reads already in flight reserve a FIFO slot, so the FIFO cannot overflow.
    assign occupancy = fifo_cnt + {2'b0, addr_v} + {2'b0, data_v};
    assign room      = occupancy < 3'd4;
    assign issue     = (state == IDLE) ? start : ((state == FETCH) && room);
    assign push      = data_v;
    assign pop       = pix_valid & pix_ready;
    assign next_addr = rom_addr + AW'(1);

    assign busy       = (state != IDLE);
    assign pix_valid  = (fifo_cnt != 3'd0);
    assign pix_data   = fifo_mem[rd_ptr];
    assign pix_opaque = pix_valid & (pix_data != TRANSP);
    assign pix_last   = pix_valid & (pix_x == X_MAX) & (pix_y == Y_MAX);

    // Fetch sequencer: issues addresses and tracks the two read stages.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            rom_addr <= '0;
            addr_v   <= 1'b0;
            data_v   <= 1'b0;
            done     <= 1'b0;
        end else begin
            addr_v <= issue;
            data_v <= addr_v;
            done   <= pop & pix_last;
            case (state)
                IDLE: begin
                    if (start) begin
                        rom_addr <= '0;
                        state    <= (LAST_ADDR == '0) ? DRAIN : FETCH;
                    end
                end
                FETCH: begin
                    if (room) begin
                        rom_addr <= next_addr;
                        if (next_addr == LAST_ADDR) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && pix_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Four-entry pixel FIFO fed straight from the ROM output.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= rom_data;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Output-side raster position, advanced on every pixel handshake.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_x <= '0;
            pix_y <= '0;
        end else if (pop) begin
            if (pix_x == X_MAX) begin
                pix_x <= '0;
                pix_y <= (pix_y == Y_MAX) ? 5'd0 : pix_y + 5'd1;
            end else begin
                pix_x <= pix_x + 5'd1;
            end
        end
    end

endmodule

// File: doc/sprite_fetch_ctrl.md
SPRITE_FETCH_CTRL -- requirements
Module: sprite_fetch_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): SPR_W, 23, sprite width in pixels.
REQ-002 The block SHALL have parameter SPR_H, 22, sprite height in pixels.
REQ-003 The block SHALL have parameter AW, 9, ROM address width; SPR_W*SPR_H <= 2**AW.
REQ-004 The block SHALL have parameter DW, 4, palette index width.
REQ-005 The block SHALL have parameter TRANSP, 4'h0, palette index treated as transparent.
REQ-006 The block SHALL have these ports (name, direction, width, meaning): Clk, in, 1, sole clock, rising edge.
REQ-007 The block SHALL have port Reset_n, in, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port start, in, 1, begin one sprite fetch; sampled only in IDLE.
REQ-009 The block SHALL have port busy, out, 1, high in any state other than IDLE.
REQ-010 The block SHALL have port done, out, 1, one-cycle pulse after the final pixel handshake.
REQ-011 The block SHALL have port rom_addr, out, AW, registered address to a synchronous ROM with 1-cycle read latency.
REQ-012 The block SHALL have port rom_data, in, DW, ROM output, valid the cycle after the edge that latched rom_addr.
REQ-013 The block SHALL have ports pix_valid, out, 1, and pix_ready, in, 1, forming the pixel stream handshake.
REQ-014 The block SHALL have ports pix_data, out, DW; pix_opaque, out, 1; pix_x, out, 5; pix_y, out, 5; pix_last, out, 1.

Function
REQ-015 The block SHALL have three states: IDLE, FETCH (issuing addresses), DRAIN (all addresses issued, pixels still pending).
REQ-016 In IDLE with start=1 at an edge, the block SHALL enter FETCH, drive rom_addr=0 and count that read as in flight.
REQ-017 Addresses SHALL be issued in row-major order 0 .. SPR_W*SPR_H-1, each exactly once, incrementing by 1.
REQ-018 A read SHALL be tracked through two in-flight stages: address issued, then data on the ROM output.
REQ-019 Data on the ROM output SHALL be pushed into a 4-entry FIFO at the next edge.
REQ-020 A new address SHALL be issued only when the registered (fifo_count + in_flight) < 4, so the FIFO never overflows.
REQ-021 With pix_ready held high, the block SHALL sustain one pixel per cycle.
REQ-022 pix_valid SHALL be high whenever the FIFO is non-empty, and pix_data SHALL be the FIFO head.
REQ-023 A pixel SHALL be consumed only on an edge where pix_valid=1 and pix_ready=1.
REQ-024 pix_data, pix_x, pix_y, pix_opaque and pix_last SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-025 pix_x and pix_y SHALL come from an output-side counter: x wraps SPR_W-1 -> 0 and increments y, starting at (0,0).
REQ-026 pix_opaque SHALL equal (pix_data != TRANSP).
REQ-027 pix_last SHALL be high on the pixel where x=SPR_W-1 and y=SPR_H-1.
REQ-028 After the last address is issued, the block SHALL go FETCH -> DRAIN and rom_addr SHALL hold its last value.
REQ-029 On the pix_last handshake, the block SHALL go DRAIN -> IDLE and pulse done in the following cycle.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 start high in the cycle done is high SHALL be accepted, because the block is in IDLE.
REQ-032 First pix_valid SHALL occur in the third cycle after the edge that accepted start, when pix_ready=1 throughout.

Reset
REQ-033 While Reset_n=0, the block SHALL asynchronously force state=IDLE, busy=0, done=0, rom_addr=0, pix_valid=0, pix_data=0, pix_opaque=0, pix_x=0, pix_y=0 and pix_last=0.
REQ-034 While Reset_n=0, the block SHALL asynchronously clear the FIFO, in-flight flags and all counters.
REQ-035 A reset mid-frame SHALL discard all pending pixels, and the next start SHALL restart from address 0.

Verification
REQ-036 Reset: drive Reset_n=0 mid-cycle -> all outputs 0 before the next edge; after release, idle with busy=0.
REQ-037 Full frame, pix_ready=1: rom_addr 0..505 on consecutive cycles; 506 pixels in consecutive cycles; first pix_valid 3 cycles after start; last pixel x=22, y=21, pix_last=1; done pulses for exactly 1 cycle.
REQ-038 Backpressure: pix_ready=0 for 10 cycles from pixel 5 -> at most 4 reads outstanding; pix_data/x/y stable; no pixel lost or duplicated against the ROM model.
REQ-039 start pulsed while busy -> ignored, single frame only; start in the done cycle -> second frame begins at address 0.
REQ-040 Reset_n=0 at pixel 100 -> immediate idle; new start -> first pixel is address 0 at (0,0).
REQ-041 ROM word 0 vs 7 -> pix_opaque=0 vs 1; random pix_ready, 20 frames -> data matches the ROM image exactly.
